psimd_fpu_issue_ctrl: RTL and testbench
=======================================

Name: psimd_fpu_issue_ctrl

Overview:
Single-issue sequencer between the PSIMD FP instruction decoder and the FP functional units (add/sub, mul, div, sqrt, sign-inject, min/max/compare, int-to-float, float-to-int, fused multiply-add/sub).
- Accepts one decoded operation at a time over a valid/ready handshake.
- Latches the operation's control fields and pulses the start line of the selected unit.
- Tracks completion with a fixed-latency counter (pipelined units) or a done input (iterative div/sqrt).
- Presents a held writeback request to the register file.

Parameters:
ADD_LAT, 3, cycles from start to result for add/sub (enc 1)
MUL_LAT, 3, mul latency (enc 2)
FMA_LAT, 5, fused multiply-add/sub latency (enc 9)
MISC_LAT, 1, latency for encodings 5, 6, 7, 8
DIV_TIMEOUT, 64, maximum EXEC cycles waiting for div_done/sqrt_done before abort

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded op valid
in_ready  out  1  block can accept an op
in_ena  in  4  unit encoding: 0 none, 1 addsub, 2 mul, 3 div, 4 sqrt, 5 sgnj, 6 minmax/cmp, 7 i2f, 8 f2i, 9 fma
in_op  in  1  add/sub or fma/fms select
in_sel1  in  2  sign-inject select
in_sel2  in  3  min/max/compare select
in_rm  in  3  rounding mode
in_rd  in  5  destination register
in_wr_en  in  1  op writes a result
unit_start  out  9  one-hot start pulse; bit k-1 corresponds to encoding k
op_q, sel1_q, sel2_q, rm_q  out  1/2/3/3  latched controls to the datapath
div_done  in  1  divider result valid
sqrt_done  in  1  sqrt result valid
wb_valid  out  1  writeback request
wb_ready  in  1  register file accepts writeback
wb_rd  out  5  writeback destination
wb_unit  out  4  encoding of the unit whose result is written (mux select)
retire  out  1  one-cycle pulse when an op completes, with or without writeback
err_illegal  out  1  one-cycle pulse: accepted op had in_ena of 0 or greater than 9
err_timeout  out  1  one-cycle pulse: div/sqrt wait aborted

Behaviour:
- Reset (async assert, sync deassert in clk domain): state IDLE; every output 0 except in_ready, which is 1 once in IDLE; all latched fields cleared. Reset during EXEC or WB discards the in-flight op with no retire, no start, and no writeback.
- States: IDLE, EXEC, WB.
- IDLE: in_ready=1. Accept on in_valid && in_ready at cycle T.
  - If in_ena is 0 or greater than 9: err_illegal=1 at T+1, stay in IDLE, nothing latched.
  - Otherwise: latch the controls, rd, wr_en and encoding; move to EXEC at T+1.
- EXEC: in_ready=0.
  - unit_start[enc-1]=1 only in the first EXEC cycle (T+1), zero in all other cycles.
  - Fixed-latency units: counter loaded with L at accept. In each EXEC cycle, if the counter is 1, go to WB; otherwise decrement. wb_valid therefore first rises at T+1+L. L≥1 is required.
  - enc 3/4: wait for the matching done signal (div_done for 3, sqrt_done for 4), sampled in every EXEC cycle including the first. On done, go to WB next cycle. The non-matching done is ignored.
  - Wait counter: if DIV_TIMEOUT EXEC cycles pass without the matching done, pulse err_timeout, go to IDLE, no retire.
- WB:
  - If the latched wr_en=1: wb_valid=1, with wb_rd and wb_unit stable until wb_valid && wb_ready. On that handshake: retire=1 that cycle, then IDLE next cycle.
  - If wr_en=0: no wb_valid; retire=1 in the first WB cycle, then IDLE.
- op_q, sel1_q, sel2_q and rm_q stay stable from accept until the op leaves WB.
- wb_ready asserted before wb_valid has no effect.
- Throughput: one op per L+2 cycles minimum; no overlap between ops.

Decomposition:
- Shared package psimd_fpu_pkg holds:
  - unit encoding constants (ENC_ADDSUB=1 … ENC_FMA=9);
  - NUM_UNITS=9;
  - state enum {IDLE, EXEC, WB}.
- Latency lookup (encoding to L, plus an is_iterative flag) is a natural combinational sub-module: psimd_fpu_lat_lut.

Test Plan:
- Add: in_ena=1, in_op=1, in_rd=7 accepted at T → unit_start=9'b000000001 at T+1 only; wb_valid at T+4, wb_rd=7, wb_unit=1; with wb_ready=1, retire at T+4 and in_ready=1 at T+5.
- Div with stall: in_ena=3, div_done high at T+12, wb_ready low for 3 cycles → wb_valid from T+13; retire on the 4th WB cycle; wb_rd held constant throughout.
- Timeout: in_ena=4, sqrt_done never asserted → err_timeout pulse after 64 EXEC cycles; no wb_valid, no retire; in_ready=1 the next cycle.
- Illegal: in_ena=0 and then in_ena=12 → err_illegal pulse each time; unit_start stays 0.
- wr_en=0: in_ena=6, in_wr_en=0 → retire at T+2 with wb_valid never asserted.
- Reset mid-op: rst_n low during FMA EXEC → all outputs 0 immediately; no retire or wb_valid after release.

Source files
------------

// File: rtl/psimd_fpu_pkg.sv
// Shared definitions for the PSIMD FP issue sequencer.
// Contents:
//   - functional-unit encodings as carried on in_ena / wb_unit
//   - NUM_UNITS, the width of the one-hot unit_start vector
//   - state_t, the sequencer state type
//   - max_int, used to size the shared latency/timeout counter
package psimd_fpu_pkg;

    localparam int NUM_UNITS = 9;

    localparam logic [3:0] ENC_NONE   = 4'd0;
    localparam logic [3:0] ENC_ADDSUB = 4'd1;
    localparam logic [3:0] ENC_MUL    = 4'd2;
    localparam logic [3:0] ENC_DIV    = 4'd3;
    localparam logic [3:0] ENC_SQRT   = 4'd4;
    localparam logic [3:0] ENC_SGNJ   = 4'd5;
    localparam logic [3:0] ENC_MINMAX = 4'd6;
    localparam logic [3:0] ENC_I2F    = 4'd7;
    localparam logic [3:0] ENC_F2I    = 4'd8;
    localparam logic [3:0] ENC_FMA    = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/psimd_fpu_lat_lut.sv
// Combinational decode of a unit encoding.
// Ports:
//   enc      in   unit encoding (0 none, 1..9 functional units)
//   legal    out  encoding names a real unit (1..9)
//   is_iter  out  unit is iterative (div/sqrt) and completes on a done input
//   lat      out  counter load value: fixed latency for pipelined units,
//                 DIV_TIMEOUT for iterative units (wait budget)
//   onehot   out  start vector, bit enc-1 set for a legal encoding
module psimd_fpu_lat_lut
    import psimd_fpu_pkg::*;
#(
    parameter int ADD_LAT     = 3,
    parameter int MUL_LAT     = 3,
    parameter int FMA_LAT     = 5,
    parameter int MISC_LAT    = 1,
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic [3:0]           enc,
    output logic                 legal,
    output logic                 is_iter,
    output logic [CNT_W-1:0]     lat,
    output logic [NUM_UNITS-1:0] onehot
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        legal   = 1'b1;
        is_iter = 1'b0;
        lat     = '0;
        onehot  = '0;
        case (enc)
            ENC_ADDSUB: lat = CNT_W'(ADD_LAT);
            ENC_MUL:    lat = CNT_W'(MUL_LAT);
            ENC_FMA:    lat = CNT_W'(FMA_LAT);
            ENC_SGNJ, ENC_MINMAX, ENC_I2F, ENC_F2I:
                        lat = CNT_W'(MISC_LAT);
            ENC_DIV, ENC_SQRT: begin
                is_iter = 1'b1;
                lat     = CNT_W'(DIV_TIMEOUT);
            end
            default:    legal = 1'b0;
        endcase
        if (legal) begin
            onehot = NUM_UNITS'(1) << (enc - 4'd1);
        end
    end

endmodule

// File: rtl/psimd_fpu_issue_ctrl.sv
// Single-issue sequencer between the PSIMD FP decoder and the FP units.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           decoded-op handshake
//   in_ena, in_op, in_sel1,
//   in_sel2, in_rm, in_rd,
//   in_wr_en                    decoded op fields
//   unit_start                  one-hot start pulse, bit k-1 for encoding k
//   op_q, sel1_q, sel2_q, rm_q  latched controls to the datapath
//   div_done, sqrt_done         completion of the iterative units
//   wb_valid/wb_ready           writeback handshake, wb_rd/wb_unit held
//   retire                      pulse when an op completes
//   err_illegal, err_timeout    error pulses
module psimd_fpu_issue_ctrl
    import psimd_fpu_pkg::*;
#(
    parameter int ADD_LAT     = 3,
    parameter int MUL_LAT     = 3,
    parameter int FMA_LAT     = 5,
    parameter int MISC_LAT    = 1,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_ena,
    input  logic                 in_op,
    input  logic [1:0]           in_sel1,
    input  logic [2:0]           in_sel2,
    input  logic [2:0]           in_rm,
    input  logic [4:0]           in_rd,
    input  logic                 in_wr_en,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic                 op_q,
    output logic [1:0]           sel1_q,
    output logic [2:0]           sel2_q,
    output logic [2:0]           rm_q,
    input  logic                 div_done,
    input  logic                 sqrt_done,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [4:0]           wb_rd,
    output logic [3:0]           wb_unit,
    output logic                 retire,
    output logic                 err_illegal,
    output logic                 err_timeout
);

    // One counter serves both the fixed latency and the div/sqrt wait
    // budget, so it is sized for the largest of them.
    localparam int MAX_CNT = max_int(max_int(max_int(ADD_LAT, MUL_LAT),
                                             max_int(FMA_LAT, MISC_LAT)),
                                     DIV_TIMEOUT);
    localparam int CNT_W = $clog2(MAX_CNT + 1);

    state_t                 state_q;
    logic [3:0]             enc_q;
    logic [4:0]             rd_q;
    logic                   wr_en_q;
    logic                   iter_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   lut_legal;
    logic                   lut_iter;
    logic [CNT_W-1:0]       lut_lat;
    logic [NUM_UNITS-1:0]   lut_onehot;
    logic                   done_match;
    logic                   cnt_last;

    psimd_fpu_lat_lut #(
        .ADD_LAT     (ADD_LAT),
        .MUL_LAT     (MUL_LAT),
        .FMA_LAT     (FMA_LAT),
        .MISC_LAT    (MISC_LAT),
        .DIV_TIMEOUT (DIV_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_lat_lut (
        .enc     (in_ena),
        .legal   (lut_legal),
        .is_iter (lut_iter),
        .lat     (lut_lat),
        .onehot  (lut_onehot)
    );

    assign done_match = (enc_q == ENC_DIV) ? div_done : sqrt_done;
    assign cnt_last   = (cnt_q == CNT_W'(1));

    // in_ready is held low while reset is asserted so that every output
    // reads 0 during reset, even though the state is already IDLE.
    assign in_ready    = (state_q == IDLE) && rst_n;
    assign wb_valid    = (state_q == WB) && wr_en_q;
    assign retire      = (state_q == WB) && (!wr_en_q || wb_ready);
    assign err_timeout = (state_q == EXEC) && iter_q && !done_match && cnt_last;
    assign wb_rd       = rd_q;
    assign wb_unit     = enc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            enc_q       <= ENC_NONE;
            rd_q        <= '0;
            wr_en_q     <= 1'b0;
            iter_q      <= 1'b0;
            cnt_q       <= '0;
            op_q        <= 1'b0;
            sel1_q      <= '0;
            sel2_q      <= '0;
            rm_q        <= '0;
            unit_start  <= '0;
            err_illegal <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; every register
            // samples pre-edge values, so statement order here is irrelevant.
            unit_start  <= '0;
            err_illegal <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (!lut_legal) begin
                            err_illegal <= 1'b1;
                        end else begin
                            enc_q      <= in_ena;
                            rd_q       <= in_rd;
                            wr_en_q    <= in_wr_en;
                            iter_q     <= lut_iter;
                            cnt_q      <= lut_lat;
                            op_q       <= in_op;
                            sel1_q     <= in_sel1;
                            sel2_q     <= in_sel2;
                            rm_q       <= in_rm;
                            unit_start <= lut_onehot;
                            state_q    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // Iterative units: done wins over an expiring budget
                    // when both fall in the same cycle.
                    if (iter_q && done_match) begin
                        state_q <= WB;
                    end else if (cnt_last) begin
                        state_q <= iter_q ? IDLE : WB;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                WB: begin
                    if (retire) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psimd_fpu_issue_ctrl.sv
// Self-checking bench for psimd_fpu_issue_ctrl.
// The stimulus is planned up front into per-cycle tables. While planning,
// a timeline model derives, from each op's accept cycle, unit latency and
// scheduled done / wb_ready events, the expected outputs for every cycle.
// A driver applies the tables just after each rising edge; a compare
// process checks every output against the expectation on the falling edge.
module tb_psimd_fpu_issue_ctrl;

    localparam int ADD_LAT     = 3;
    localparam int MUL_LAT     = 3;
    localparam int FMA_LAT     = 5;
    localparam int MISC_LAT    = 1;
    localparam int DIV_TIMEOUT = 64;
    localparam int N           = 210;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_ena;
    logic       in_op;
    logic [1:0] in_sel1;
    logic [2:0] in_sel2;
    logic [2:0] in_rm;
    logic [4:0] in_rd;
    logic       in_wr_en;
    logic [8:0] unit_start;
    logic       op_q;
    logic [1:0] sel1_q;
    logic [2:0] sel2_q;
    logic [2:0] rm_q;
    logic       div_done;
    logic       sqrt_done;
    logic       wb_valid;
    logic       wb_ready;
    logic [4:0] wb_rd;
    logic [3:0] wb_unit;
    logic       retire;
    logic       err_illegal;
    logic       err_timeout;

    psimd_fpu_issue_ctrl #(
        .ADD_LAT     (ADD_LAT),
        .MUL_LAT     (MUL_LAT),
        .FMA_LAT     (FMA_LAT),
        .MISC_LAT    (MISC_LAT),
        .DIV_TIMEOUT (DIV_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ena      (in_ena),
        .in_op       (in_op),
        .in_sel1     (in_sel1),
        .in_sel2     (in_sel2),
        .in_rm       (in_rm),
        .in_rd       (in_rd),
        .in_wr_en    (in_wr_en),
        .unit_start  (unit_start),
        .op_q        (op_q),
        .sel1_q      (sel1_q),
        .sel2_q      (sel2_q),
        .rm_q        (rm_q),
        .div_done    (div_done),
        .sqrt_done   (sqrt_done),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_unit     (wb_unit),
        .retire      (retire),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-cycle stimulus tables.
    logic       drv_rstn  [N];
    logic       drv_valid [N];
    logic [3:0] drv_ena   [N];
    logic       drv_op    [N];
    logic [1:0] drv_sel1  [N];
    logic [2:0] drv_sel2  [N];
    logic [2:0] drv_rm    [N];
    logic [4:0] drv_rd    [N];
    logic       drv_wr    [N];
    logic       drv_div   [N];
    logic       drv_sqrt  [N];
    logic       drv_wbr   [N];

    // Per-cycle expectations.
    logic       exp_ready [N];
    logic [8:0] exp_start [N];
    logic       exp_wbv   [N];
    logic [4:0] exp_wbrd  [N];
    logic [3:0] exp_wbu   [N];
    logic       exp_ret   [N];
    logic       exp_ill   [N];
    logic       exp_to    [N];
    logic       exp_ctl   [N];
    logic       exp_op    [N];
    logic [1:0] exp_sel1  [N];
    logic [2:0] exp_sel2  [N];
    logic [2:0] exp_rm    [N];
    logic       exp_zero  [N];

    int n_checks = 0;
    int n_fail   = 0;
    int cur_cyc  = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cur_cyc, act, exp);
        end
    endtask

    function automatic int unit_lat(input logic [3:0] ena);
        case (ena)
            4'd1:    return ADD_LAT;
            4'd2:    return MUL_LAT;
            4'd9:    return FMA_LAT;
            default: return MISC_LAT;
        endcase
    endfunction

    task automatic clear_from(input int r);
        for (int c = r; c < N; c++) begin
            drv_valid[c] = 1'b0; drv_ena[c] = '0; drv_op[c] = 1'b0;
            drv_sel1[c] = '0; drv_sel2[c] = '0; drv_rm[c] = '0;
            drv_rd[c] = '0; drv_wr[c] = 1'b0; drv_div[c] = 1'b0;
            drv_sqrt[c] = 1'b0; drv_wbr[c] = 1'b0;
            exp_ready[c] = 1'b1; exp_start[c] = '0; exp_wbv[c] = 1'b0;
            exp_wbrd[c] = '0; exp_wbu[c] = '0; exp_ret[c] = 1'b0;
            exp_ill[c] = 1'b0; exp_to[c] = 1'b0; exp_ctl[c] = 1'b0;
            exp_op[c] = 1'b0; exp_sel1[c] = '0; exp_sel2[c] = '0;
            exp_rm[c] = '0; exp_zero[c] = 1'b0;
        end
    endtask

    // Reset asserted for cycles r .. r+len-1; anything in flight is gone.
    task automatic plan_reset(input int r, input int len, output int nxt);
        clear_from(r);
        for (int c = r; c < r + len; c++) begin
            drv_rstn[c]  = 1'b0;
            exp_ready[c] = 1'b0;
            exp_zero[c]  = 1'b1;
        end
        nxt = r + len;
    endtask

    // Op presented in cycle t while idle. done_at: cycle the matching done
    // is driven (0 = never). wbr_delay: WB cycles with wb_ready low before
    // the handshake. pre_wbr: hold wb_ready high during EXEC.
    task automatic plan_op(input int t, input logic [3:0] ena, input logic op,
                           input logic [1:0] s1, input logic [2:0] s2,
                           input logic [2:0] rm, input logic [4:0] rd,
                           input logic wr, input int done_at, input int wbr_delay,
                           input bit pre_wbr, output int nxt);
        int  e;
        int  w;
        bit  timed_out;
        drv_valid[t] = 1'b1; drv_ena[t] = ena; drv_op[t] = op;
        drv_sel1[t] = s1; drv_sel2[t] = s2; drv_rm[t] = rm;
        drv_rd[t] = rd; drv_wr[t] = wr;
        if (ena == 4'd0 || ena > 4'd9) begin
            exp_ill[t+1] = 1'b1;
            nxt = t + 1;
            return;
        end
        exp_start[t+1] = 9'd1 << (ena - 4'd1);
        timed_out = 1'b0;
        if (ena == 4'd3 || ena == 4'd4) begin
            if (done_at > t && done_at <= t + DIV_TIMEOUT) begin
                e = done_at;
                if (ena == 4'd3) drv_div[e] = 1'b1;
                else             drv_sqrt[e] = 1'b1;
            end else begin
                e = t + DIV_TIMEOUT;
                exp_to[e] = 1'b1;
                timed_out = 1'b1;
            end
        end else begin
            e = t + unit_lat(ena);
        end
        w = timed_out ? e : (wr ? e + 1 + wbr_delay : e + 1);
        for (int c = t + 1; c <= w; c++) begin
            exp_ready[c] = 1'b0;
            exp_ctl[c] = 1'b1; exp_op[c] = op; exp_sel1[c] = s1;
            exp_sel2[c] = s2; exp_rm[c] = rm;
            if (pre_wbr && c <= e) drv_wbr[c] = 1'b1;
            if (!timed_out && wr && c > e) begin
                exp_wbv[c] = 1'b1; exp_wbrd[c] = rd; exp_wbu[c] = ena;
            end
        end
        if (!timed_out) begin
            exp_ret[w] = 1'b1;
            if (wr) drv_wbr[w] = 1'b1;
        end
        nxt = w + 1;
    endtask

    task automatic plan_all();
        int t;
        int n;
        for (int c = 0; c < N; c++) drv_rstn[c] = 1'b1;
        clear_from(0);
        plan_reset(0, 3, t);
        t = 4;
        // add, rd 7: start at 5 only, wb_valid/retire at 8, ready at 9
        plan_op(t, 4'd1, 1'b1, 2'd0, 3'd0, 3'd0, 5'd7, 1'b1, 0, 0, 1'b0, n);
        check("pin_add_next", n, 9);
        check("pin_add_start", exp_start[5], 9'b000000001);
        check("pin_add_wbv_early", exp_wbv[7], 1'b0);
        check("pin_add_retire", exp_ret[8], 1'b1);
        drv_valid[6] = 1'b1; drv_ena[6] = 4'd5; drv_rd[6] = 5'd31;  // ignored while busy
        t = n;
        plan_op(t, 4'd2, 1'b0, 2'd2, 3'd5, 3'd3, 5'd3, 1'b1, 0, 1, 1'b1, n);
        t = n;
        // div accepted at 15, done at 27, wb_ready low for 3 WB cycles
        plan_op(t, 4'd3, 1'b1, 2'd1, 3'd3, 3'd1, 5'd17, 1'b1, t + 12, 3, 1'b0, n);
        drv_sqrt[t+2] = 1'b1;
        check("pin_div_next", n, 32);
        check("pin_div_wbv_first", exp_wbv[28], 1'b1);
        check("pin_div_retire", exp_ret[31], 1'b1);
        t = n;
        // sqrt accepted at 32 never completes: err_timeout at 96
        plan_op(t, 4'd4, 1'b0, 2'd0, 3'd2, 3'd2, 5'd9, 1'b1, 0, 0, 1'b0, n);
        drv_div[t+5] = 1'b1;
        check("pin_to_pulse", exp_to[96], 1'b1);
        check("pin_to_next", n, 97);
        t = n;
        plan_op(t, 4'd0, 1'b0, 2'd0, 3'd0, 3'd0, 5'd4, 1'b1, 0, 0, 1'b0, n);
        t = n;
        plan_op(t, 4'd12, 1'b1, 2'd3, 3'd7, 3'd7, 5'd4, 1'b1, 0, 0, 1'b0, n);
        check("pin_ill_second", exp_ill[99], 1'b1);
        t = n;
        // minmax, no writeback: retire at t+2 = 101
        plan_op(t, 4'd6, 1'b0, 2'd0, 3'd4, 3'd5, 5'd5, 1'b0, 0, 0, 1'b1, n);
        check("pin_nowr_retire", exp_ret[101], 1'b1);
        check("pin_nowr_wbv", exp_wbv[101], 1'b0);
        t = n;
        plan_op(t, 4'd5, 1'b1, 2'd1, 3'd0, 3'd6, 5'd1, 1'b1, 0, 0, 1'b0, n);
        t = n;
        plan_op(t, 4'd7, 1'b0, 2'd3, 3'd1, 3'd4, 5'd30, 1'b1, 0, 0, 1'b0, n);
        t = n;
        plan_op(t, 4'd8, 1'b1, 2'd2, 3'd6, 3'd0, 5'd31, 1'b1, 0, 2, 1'b0, n);
        t = n;
        // sqrt done sampled in its first EXEC cycle
        plan_op(t, 4'd4, 1'b1, 2'd0, 3'd1, 3'd2, 5'd12, 1'b1, t + 1, 0, 1'b0, n);
        t = n;
        // div done in the last cycle of the wait budget still completes
        plan_op(t, 4'd3, 1'b0, 2'd1, 3'd2, 3'd3, 5'd20, 1'b0, t + DIV_TIMEOUT, 0, 1'b0, n);
        check("pin_div_edge_retire", exp_ret[t + DIV_TIMEOUT + 1], 1'b1);
        t = n;
        // fma interrupted by reset in its third EXEC cycle
        plan_op(t, 4'd9, 1'b1, 2'd2, 3'd5, 3'd1, 5'd21, 1'b1, 0, 0, 1'b0, n);
        plan_reset(t + 3, 2, n);
        t = n + 1;
        plan_op(t, 4'd9, 1'b0, 2'd1, 3'd3, 3'd2, 5'd22, 1'b1, 0, 0, 1'b0, n);
        t = n;
        plan_op(t, 4'd1, 1'b0, 2'd3, 3'd7, 3'd7, 5'd2, 1'b1, 0, 0, 1'b0, n);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ena = '0; in_op = 1'b0;
        in_sel1 = '0; in_sel2 = '0; in_rm = '0; in_rd = '0; in_wr_en = 1'b0;
        div_done = 1'b0; sqrt_done = 1'b0; wb_ready = 1'b0;
        plan_all();
        fork
            begin
                for (int c = 0; c < N; c++) begin
                    @(posedge clk);
                    #1;
                    rst_n = drv_rstn[c]; in_valid = drv_valid[c];
                    in_ena = drv_ena[c]; in_op = drv_op[c];
                    in_sel1 = drv_sel1[c]; in_sel2 = drv_sel2[c];
                    in_rm = drv_rm[c]; in_rd = drv_rd[c]; in_wr_en = drv_wr[c];
                    div_done = drv_div[c]; sqrt_done = drv_sqrt[c];
                    wb_ready = drv_wbr[c];
                end
            end
            begin
                for (int c = 0; c < N; c++) begin
                    @(negedge clk);
                    cur_cyc = c;
                    check("in_ready", in_ready, exp_ready[c]);
                    check("unit_start", unit_start, exp_start[c]);
                    check("wb_valid", wb_valid, exp_wbv[c]);
                    check("retire", retire, exp_ret[c]);
                    check("err_illegal", err_illegal, exp_ill[c]);
                    check("err_timeout", err_timeout, exp_to[c]);
                    if (exp_wbv[c]) begin
                        check("wb_rd", wb_rd, exp_wbrd[c]);
                        check("wb_unit", wb_unit, exp_wbu[c]);
                    end
                    if (exp_ctl[c]) begin
                        check("op_q", op_q, exp_op[c]);
                        check("sel1_q", sel1_q, exp_sel1[c]);
                        check("sel2_q", sel2_q, exp_sel2[c]);
                        check("rm_q", rm_q, exp_rm[c]);
                    end
                    if (exp_zero[c]) begin
                        check("rst_wb_rd", wb_rd, 5'd0);
                        check("rst_wb_unit", wb_unit, 4'd0);
                        check("rst_ctl", {op_q, sel1_q, sel2_q, rm_q}, 9'd0);
                    end
                end
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
